// File: rtl/cam_wr_ctrl.sv
// cam_wr_ctrl: write-side front end for cam2. Buffers insert/invalidate
// requests in a FIFO, allocates the lowest free entry and drives cam2.
// Ports: req_* valid/ready request in; write_/w_addr/wdata/new_tag/new_valid
// to cam2; done_* completion pulse; full/free_cnt from the shadow valid map.
module cam_wr_ctrl #(
    parameter int BITS   = 8,
    parameter int TAG_SZ = 8,
    parameter int WORDS  = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_op,
    input  logic [TAG_SZ-1:0]        req_tag,
    input  logic [BITS-1:0]          req_data,
    input  logic [$clog2(WORDS)-1:0] req_addr,
    output logic                     write_,
    output logic [$clog2(WORDS)-1:0] w_addr,
    output logic [BITS-1:0]          wdata,
    output logic [TAG_SZ-1:0]        new_tag,
    output logic                     new_valid,
    output logic                     done_valid,
    output logic [$clog2(WORDS)-1:0] done_addr,
    output logic                     done_err,
    output logic                     full,
    output logic [$clog2(WORDS):0]   free_cnt
);

    localparam int AW = $clog2(WORDS);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 1 + TAG_SZ + BITS + AW;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t state_q, state_d;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;

    logic [WORDS-1:0]  shadow_q, shadow_d;
    logic              write_q, write_d;
    logic [AW-1:0]     w_addr_q, w_addr_d;
    logic [BITS-1:0]   wdata_q, wdata_d;
    logic [TAG_SZ-1:0] new_tag_q, new_tag_d;
    logic              new_valid_q, new_valid_d;
    logic              done_valid_q, done_valid_d;
    logic [AW-1:0]     done_addr_q, done_addr_d;
    logic              done_err_q, done_err_d;

    logic              fifo_full, fifo_empty, push, pop;
    logic              h_op;
    logic [TAG_SZ-1:0] h_tag;
    logic [BITS-1:0]   h_data;
    logic [AW-1:0]     h_addr;
    logic [AW-1:0]     free_idx;
    logic [AW:0]       free_cnt_c;

    assign fifo_full  = (cnt_q == (PW+1)'(DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign req_ready  = !fifo_full && rst_;
    assign push       = req_valid && req_ready;
    assign pop        = (state_q == IDLE) && !fifo_empty;

    assign {h_op, h_tag, h_data, h_addr} = mem_q[rd_ptr_q];

    // Scan from the top so the last hit is the lowest free index.
    always_comb begin
        free_idx   = '0;
        free_cnt_c = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (!shadow_q[i]) begin
                free_idx   = AW'(i);
                free_cnt_c = free_cnt_c + (AW+1)'(1);
            end
        end
    end

    assign full     = &shadow_q;
    assign free_cnt = free_cnt_c;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: a rejected insert completes without leaving IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pop && (h_op || !full)) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs and shadow map; cam2 data lines hold until the next issue.
    always_comb begin
        shadow_d     = shadow_q;
        write_d      = 1'b1;
        w_addr_d     = w_addr_q;
        wdata_d      = wdata_q;
        new_tag_d    = new_tag_q;
        new_valid_d  = new_valid_q;
        done_valid_d = 1'b0;
        done_addr_d  = done_addr_q;
        done_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    if (h_op) begin
                        write_d          = 1'b0;
                        w_addr_d         = h_addr;
                        wdata_d          = '0;
                        new_tag_d        = '0;
                        new_valid_d      = 1'b0;
                        shadow_d[h_addr] = 1'b0;
                    end else if (!full) begin
                        write_d            = 1'b0;
                        w_addr_d           = free_idx;
                        wdata_d            = h_data;
                        new_tag_d          = h_tag;
                        new_valid_d        = 1'b1;
                        shadow_d[free_idx] = 1'b1;
                    end else begin
                        done_valid_d = 1'b1;
                        done_err_d   = 1'b1;
                        done_addr_d  = '0;
                    end
                end
            end
            WRITE: begin
                done_valid_d = 1'b1;
                done_addr_d  = w_addr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            write_q      <= 1'b1;
            w_addr_q     <= '0;
            wdata_q      <= '0;
            new_tag_q    <= '0;
            new_valid_q  <= 1'b0;
            done_valid_q <= 1'b0;
            done_addr_q  <= '0;
            done_err_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            write_q      <= write_d;
            w_addr_q     <= w_addr_d;
            wdata_q      <= wdata_d;
            new_tag_q    <= new_tag_d;
            new_valid_q  <= new_valid_d;
            done_valid_q <= done_valid_d;
            done_addr_q  <= done_addr_d;
            done_err_q   <= done_err_d;
        end
    end

    // Storage needs no reset; the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_op, req_tag, req_data, req_addr};
    end

    assign write_     = write_q;
    assign w_addr     = w_addr_q;
    assign wdata      = wdata_q;
    assign new_tag    = new_tag_q;
    assign new_valid  = new_valid_q;
    assign done_valid = done_valid_q;
    assign done_addr  = done_addr_q;
    assign done_err   = done_err_q;

endmodule
